// File: rtl/calc_arb_pkg.sv
// ============================================================================
//  Module      : calc_arb_pkg
//  Description : Shared definitions for the calculator command arbiter.
//                - Arbiter FSM state encoding (3 bits).
//                - Calculator opcode and address widths.
//                - Width of the optional watchdog counter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package calc_arb_pkg;

  // Calculator command field widths.
  localparam int OPCODE_W      = 4;
  localparam int ADDR_W        = 8;

  // Watchdog counter width. Only used when CALC_ARB_TIMEOUT_EN is defined.
  localparam int TIMEOUT_CNT_W = 32;

  // Arbiter FSM states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DONE      = 3'd4
  } arb_state_e;

endpackage : calc_arb_pkg

`default_nettype wire

// File: rtl/calc_cmd_arbiter_rr_pick.sv
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin selector. Searches the request
//                vector upward from ptr_i+1 (modulo NUM_REQ) and returns the
//                first requester that is set.
//  Ports       : req_i     [NUM_REQ-1:0]  request vector
//                ptr_i     [IDX_W-1:0]    index of the last winner
//                winner_o  [IDX_W-1:0]    selected requester index
//                valid_o                  at least one request is set
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick
  import calc_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   winner_o,
  output logic               valid_o
);

  // One extra bit holds ptr + offset before the modulo wrap; since
  // ptr < NUM_REQ and offset <= NUM_REQ the sum always fits.
  logic [IDX_W:0] w_sum;

  // Walk offsets from farthest to nearest so the nearest set request
  // (highest priority) is the last assignment and wins without a break.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    w_sum    = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      w_sum = {1'b0, ptr_i} + (IDX_W+1)'(off);
      if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
      end
      if (req_i[w_sum[IDX_W-1:0]]) begin
        winner_o = w_sum[IDX_W-1:0];
        valid_o  = 1'b1;
      end
    end
  end

endmodule : rr_pick

`default_nettype wire

// File: rtl/calc_cmd_arbiter.sv
// ============================================================================
//  Module      : calc_cmd_arbiter
//  Description : Round-robin arbiter sharing one calculator datapath among
//                NUM_REQ requesters. Issues one command at a time, follows the
//                calculator busy handshake to completion and returns a
//                one-cycle done pulse to the owner.
//  Ports       : clk_i            system clock, rising edge
//                rst_ni           asynchronous active-low reset
//                req_i            per-requester level request
//                req_a_i/req_b_i  packed operands, lane i at [i*WIDTH +: WIDTH]
//                req_sel_i        packed 4-bit opcodes
//                req_addr_i       packed 8-bit addresses
//                req_rw_i         per-requester read/write bit
//                calc_active_i    calculator enabled; gates new grants
//                busy_i           calculator busy handshake
//                grant_o          one-hot owner of the current transaction
//                done_o           one-cycle completion pulse to the owner
//                timeout_o        watchdog expiry, coincident with done_o
//                valid_cmd_o      one-cycle command strobe
//                in_a_o/in_b_o    latched operands
//                sel_o/addr_o     latched opcode / address
//                rw_mem_o         latched read/write bit
//  Options     : CALC_ARB_TIMEOUT_EN  builds the busy-handshake watchdog
//                (TIMEOUT_CYCLES). Undefined: timeout_o is tied low and the
//                arbiter waits on busy indefinitely.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module calc_cmd_arbiter
  import calc_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ*WIDTH-1:0]    req_a_i,
  input  logic [NUM_REQ*WIDTH-1:0]    req_b_i,
  input  logic [NUM_REQ*OPCODE_W-1:0] req_sel_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ-1:0]          req_rw_i,
  input  logic                        calc_active_i,
  input  logic                        busy_i,
  output logic [NUM_REQ-1:0]          grant_o,
  output logic [NUM_REQ-1:0]          done_o,
  output logic                        timeout_o,
  output logic                        valid_cmd_o,
  output logic [WIDTH-1:0]            in_a_o,
  output logic [WIDTH-1:0]            in_b_o,
  output logic [OPCODE_W-1:0]         sel_o,
  output logic [ADDR_W-1:0]           addr_o,
  output logic                        rw_mem_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     ptr_q;
  logic [IDX_W-1:0]     owner_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [WIDTH-1:0]     in_a_q, in_b_q;
  logic [OPCODE_W-1:0]  sel_q;
  logic [ADDR_W-1:0]    addr_q;
  logic                 rw_q;

  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;
  logic                 start;
  logic                 timeout_hit;
  logic                 timeout_flag;

  // --------------------------------------------------------------------------
  // Round-robin winner selection
  // --------------------------------------------------------------------------
  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i    (req_i),
    .ptr_i    (ptr_q),
    .winner_o (pick_idx),
    .valid_o  (pick_valid)
  );

  assign start = (state_q == ST_IDLE) && calc_active_i && pick_valid;

  // --------------------------------------------------------------------------
  // Optional watchdog on the busy handshake
  // --------------------------------------------------------------------------
`ifdef CALC_ARB_TIMEOUT_EN
  logic [TIMEOUT_CNT_W-1:0] wdog_cnt_q;
  logic                     timeout_flag_q;

  assign timeout_hit = ((state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE)) &&
                       (wdog_cnt_q == TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_flag = timeout_flag_q;

  // Counter is cleared while in ISSUE so it reads 0 on the first WAIT_BUSY
  // cycle. The flag records whether DONE was reached through expiry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_cnt_q     <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      if (state_q == ST_ISSUE) begin
        wdog_cnt_q     <= '0;
        timeout_flag_q <= 1'b0;
      end else if ((state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE)) begin
        wdog_cnt_q     <= wdog_cnt_q + 1'b1;
        timeout_flag_q <= timeout_hit;
      end
    end
  end
`else
  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // Watchdog expiry takes precedence over the busy handshake so the counter
  // can never run past its limit.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (timeout_hit) begin
          state_d = ST_DONE;
        end else if (busy_i) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (timeout_hit || !busy_i) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs decoded from the registered state
  // --------------------------------------------------------------------------
  always_comb begin
    valid_cmd_o = 1'b0;
    done_o      = '0;
    timeout_o   = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        valid_cmd_o = 1'b1;
      end
      ST_DONE: begin
        // grant_q still marks the owner during DONE.
        done_o    = grant_q;
        timeout_o = timeout_flag;
      end
      default: begin
        valid_cmd_o = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Grant, round-robin pointer and latched command fields
  // Operands are loaded only on a new grant, so they stay frozen for the
  // whole transaction and hold afterwards until the next grant.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_q <= '0;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      owner_q <= '0;
      in_a_q  <= '0;
      in_b_q  <= '0;
      sel_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
    end else begin
      if (start) begin
        grant_q <= NUM_REQ'(1) << pick_idx;
        owner_q <= pick_idx;
        in_a_q  <= req_a_i[int'(pick_idx)*WIDTH +: WIDTH];
        in_b_q  <= req_b_i[int'(pick_idx)*WIDTH +: WIDTH];
        sel_q   <= req_sel_i[int'(pick_idx)*OPCODE_W +: OPCODE_W];
        addr_q  <= req_addr_i[int'(pick_idx)*ADDR_W +: ADDR_W];
        rw_q    <= req_rw_i[pick_idx];
      end else if (state_q == ST_DONE) begin
        // The finished owner drops to lowest priority for the next round.
        grant_q <= '0;
        ptr_q   <= owner_q;
      end
    end
  end

  assign grant_o  = grant_q;
  assign in_a_o   = in_a_q;
  assign in_b_o   = in_b_q;
  assign sel_o    = sel_q;
  assign addr_o   = addr_q;
  assign rw_mem_o = rw_q;

endmodule : calc_cmd_arbiter

`default_nettype wire

// File: tb/tb_calc_cmd_arbiter.sv
// ============================================================================
//  Module      : tb_calc_cmd_arbiter
//  Description : Directed self-checking bench for calc_cmd_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_calc_cmd_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*WIDTH-1:0] req_a, req_b;
  logic [NUM_REQ*4-1:0] req_sel;
  logic [NUM_REQ*8-1:0] req_addr;
  logic [NUM_REQ-1:0]   req_rw;
  logic                 calc_active;
  logic                 busy;
  logic [NUM_REQ-1:0]   grant, done;
  logic                 timeout, valid_cmd;
  logic [WIDTH-1:0]     in_a, in_b;
  logic [3:0]           sel;
  logic [7:0]           addr;
  logic                 rw_mem;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  calc_cmd_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .WIDTH          (WIDTH),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_i         (req),
    .req_a_i       (req_a),
    .req_b_i       (req_b),
    .req_sel_i     (req_sel),
    .req_addr_i    (req_addr),
    .req_rw_i      (req_rw),
    .calc_active_i (calc_active),
    .busy_i        (busy),
    .grant_o       (grant),
    .done_o        (done),
    .timeout_o     (timeout),
    .valid_cmd_o   (valid_cmd),
    .in_a_o        (in_a),
    .in_b_o        (in_b),
    .sel_o         (sel),
    .addr_o        (addr),
    .rw_mem_o      (rw_mem)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = 8'(8'h10 + i);
      req_b[i*WIDTH +: WIDTH] = 8'(8'h20 + i);
      req_sel[i*4 +: 4]       = 4'(i + 1);
      req_addr[i*8 +: 8]      = 8'(8'h40 + i);
      req_rw[i]               = (i % 2) == 1;
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    busy  = 1'b0;
    req   = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    nvec++;
    if (grant !== 4'b0000) begin nmis++; $display("FAIL reset_grant: got %b expected %b", grant, 4'b0000); end
    nvec++;
    if (done !== 4'b0000) begin nmis++; $display("FAIL reset_done: got %b expected %b", done, 4'b0000); end
    nvec++;
    if ({valid_cmd, timeout} !== 2'b00) begin nmis++; $display("FAIL reset_valid_timeout: got %b expected 00", {valid_cmd, timeout}); end
    nvec++;
    if ({in_a, in_b, sel, addr, rw_mem} !== 29'd0) begin
      nmis++; $display("FAIL reset_operands: got %h expected 0", {in_a, in_b, sel, addr, rw_mem});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    set_lanes();
    req_a[7:0]  = 8'h05;
    req_b[7:0]  = 8'h03;
    req_sel[3:0] = 4'h0;
    calc_active = 1'b1;
    req = 4'b0001;
    tick(); // ISSUE
    nvec++;
    if (valid_cmd !== 1'b1) begin nmis++; $display("FAIL single_valid: got %b expected 1", valid_cmd); end
    nvec++;
    if (grant !== 4'b0001) begin nmis++; $display("FAIL single_grant: got %b expected 0001", grant); end
    nvec++;
    if ({in_a, in_b, sel} !== {8'h05, 8'h03, 4'h0}) begin
      nmis++; $display("FAIL single_operands: got %h/%h/%h expected 05/03/0", in_a, in_b, sel);
    end
    tick(); // WAIT_BUSY
    nvec++;
    if (valid_cmd !== 1'b0) begin nmis++; $display("FAIL single_valid_once: got %b expected 0", valid_cmd); end
    busy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      nvec++;
      if (done !== 4'b0000) begin nmis++; $display("FAIL single_early_done: got %b expected 0000 (cycle %0d)", done, c); end
    end
    busy = 1'b0;
    tick(); // DONE
    nvec++;
    if (done !== 4'b0001) begin nmis++; $display("FAIL single_done: got %b expected 0001", done); end
    nvec++;
    if ({timeout, grant} !== 5'b0_0001) begin nmis++; $display("FAIL single_done_state: got %b expected 00001", {timeout, grant}); end
    req = 4'b0000;
    tick(); // IDLE
    nvec++;
    if ({done, grant} !== 8'h00) begin nmis++; $display("FAIL single_after: got %b expected 00000000", {done, grant}); end
    nvec++;
    if (in_a !== 8'h05) begin nmis++; $display("FAIL single_hold: got %h expected 05", in_a); end
  endtask

  task automatic test_contention;
    logic [3:0] exp;
    int lane;
    do_reset();
    set_lanes();
    calc_active = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      lane = k % 4;
      exp  = 4'(1 << lane);
      tick(); // ISSUE
      nvec++;
      if ({valid_cmd, grant} !== {1'b1, exp}) begin
        nmis++; $display("FAIL contention_grant%0d: got valid=%b grant=%b expected valid=1 grant=%b", k, valid_cmd, grant, exp);
      end
      nvec++;
      if ({in_a, sel, addr, rw_mem} !== {8'(8'h10 + lane), 4'(lane + 1), 8'(8'h40 + lane), (lane % 2) == 1}) begin
        nmis++; $display("FAIL contention_fields%0d: got %h/%h/%h/%b", k, in_a, sel, addr, rw_mem);
      end
      busy = 1'b1;
      tick(); // WAIT_BUSY
      nvec++;
      if (valid_cmd !== 1'b0) begin nmis++; $display("FAIL contention_valid_once%0d: got %b expected 0", k, valid_cmd); end
      tick(); // WAIT_DONE
      busy = 1'b0;
      tick(); // DONE
      nvec++;
      if ({valid_cmd, done} !== {1'b0, exp}) begin
        nmis++; $display("FAIL contention_done%0d: got valid=%b done=%b expected valid=0 done=%b", k, valid_cmd, done, exp);
      end
      tick(); // IDLE gap before next grant
      nvec++;
      if ({valid_cmd, grant, done} !== 9'd0) begin
        nmis++; $display("FAIL contention_gap%0d: got %b expected 0", k, {valid_cmd, grant, done});
      end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_gating;
    do_reset();
    calc_active = 1'b0;
    req = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      tick();
      nvec++;
      if ({valid_cmd, grant} !== 5'b0) begin
        nmis++; $display("FAIL gating_blocked%0d: got %b expected 00000", c, {valid_cmd, grant});
      end
    end
    calc_active = 1'b1;
    tick();
    nvec++;
    if ({valid_cmd, grant} !== 5'b1_0010) begin
      nmis++; $display("FAIL gating_grant: got %b expected 10010", {valid_cmd, grant});
    end
    busy = 1'b1;
    tick();
    tick();
    busy = 1'b0;
    tick();
    nvec++;
    if (done !== 4'b0010) begin nmis++; $display("FAIL gating_done: got %b expected 0010", done); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_req_drop;
    req = 4'b0100;
    tick(); // ISSUE
    nvec++;
    if (grant !== 4'b0100) begin nmis++; $display("FAIL drop_grant: got %b expected 0100", grant); end
    tick(); // WAIT_BUSY
    req  = 4'b0000;
    busy = 1'b1;
    tick(); // WAIT_DONE
    busy = 1'b0;
    tick(); // DONE
    nvec++;
    if (done !== 4'b0100) begin nmis++; $display("FAIL drop_done: got %b expected 0100", done); end
    tick();
    nvec++;
    if ({valid_cmd, grant, done} !== 9'd0) begin
      nmis++; $display("FAIL drop_idle: got %b expected 0", {valid_cmd, grant, done});
    end
  endtask

  task automatic test_reset_mid;
    req = 4'b0001;
    tick(); // ISSUE
    busy = 1'b1;
    tick(); // WAIT_BUSY
    tick(); // WAIT_DONE
    nvec++;
    if (in_a !== 8'h10) begin nmis++; $display("FAIL midreset_pre: got %h expected 10", in_a); end
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({grant, done, valid_cmd} !== 9'd0) begin
      nmis++; $display("FAIL midreset_ctrl: got %b expected 0", {grant, done, valid_cmd});
    end
    nvec++;
    if ({in_a, in_b, sel, addr, rw_mem} !== 29'd0) begin
      nmis++; $display("FAIL midreset_operands: got %h expected 0", {in_a, in_b, sel, addr, rw_mem});
    end
    busy = 1'b0;
    req  = 4'b1000;
    tick();
    rst_n = 1'b1;
    tick(); // ISSUE
    nvec++;
    if ({grant, done, valid_cmd} !== 9'b1000_0000_1) begin
      nmis++; $display("FAIL midreset_regrant: got %b expected 100000001", {grant, done, valid_cmd});
    end
    busy = 1'b1;
    tick();
    tick();
    busy = 1'b0;
    tick(); // DONE
    nvec++;
    if (done !== 4'b1000) begin nmis++; $display("FAIL midreset_done: got %b expected 1000", done); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_watchdog;
    req  = 4'b0010;
    busy = 1'b0;
    tick(); // ISSUE
    nvec++;
    if ({valid_cmd, grant} !== 5'b1_0010) begin
      nmis++; $display("FAIL wdog_issue: got %b expected 10010", {valid_cmd, grant});
    end
    tick(); // first WAIT_BUSY cycle
`ifdef CALC_ARB_TIMEOUT_EN
    for (int c = 1; c < 16; c++) begin
      tick();
      nvec++;
      if ({done, timeout} !== 5'b0) begin nmis++; $display("FAIL wdog_early%0d: got %b expected 0", c, {done, timeout}); end
    end
    tick();
    nvec++;
    if ({done, timeout} !== 5'b0010_1) begin
      nmis++; $display("FAIL wdog_expire: got %b expected 00101", {done, timeout});
    end
    req = 4'b0000;
    tick();
    nvec++;
    if ({done, timeout, grant} !== 9'd0) begin
      nmis++; $display("FAIL wdog_after: got %b expected 0", {done, timeout, grant});
    end
`else
    for (int c = 1; c < 40; c++) begin
      tick();
      nvec++;
      if ({done, timeout} !== 5'b0) begin nmis++; $display("FAIL wait_forever%0d: got %b expected 0", c, {done, timeout}); end
    end
    busy = 1'b1;
    tick();
    busy = 1'b0;
    tick();
    nvec++;
    if ({done, timeout} !== 5'b0010_0) begin
      nmis++; $display("FAIL wait_done: got %b expected 00100", {done, timeout});
    end
    req = 4'b0000;
    tick();
`endif
  endtask

  initial begin
    rst_n       = 1'b0;
    req         = '0;
    req_a       = '0;
    req_b       = '0;
    req_sel     = '0;
    req_addr    = '0;
    req_rw      = '0;
    calc_active = 1'b0;
    busy        = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_gating();
    test_req_drop();
    test_reset_mid();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule : tb_calc_cmd_arbiter

`default_nettype wire

// File: doc/calc_cmd_arbiter.md
# calc_cmd_arbiter

Round-robin command arbiter that shares the single calculator datapath among NUM_REQ requesters. It sits in front of the calculator top-level and drives its command inputs: validCmd, rwMem, addr, InA, InB and sel. It issues one command at a time, tracks the calculator's busy handshake to completion, and returns a per-requester done pulse.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- WIDTH, 8: operand width; matches the calculator width.
- TIMEOUT_CYCLES, 1024: watchdog limit. Used only when the watchdog is compiled in.

- clk  in  1  system clock; all state is updated on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state.
- req  in  NUM_REQ  per-requester command request; level-sensitive.
- reqA  in  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- reqB  in  NUM_REQ*WIDTH  operand B; packed the same way as reqA.
- reqSel  in  NUM_REQ*4  ALU opcode per requester.
- reqAddr  in  NUM_REQ*8  memory address per requester.
- reqRw  in  NUM_REQ  memory read/write bit per requester.
- calcActive  in  1  calculator enabled; no new grant is issued while this is 0.
- busy  in  1  calculator controller busy.
- grant  out  NUM_REQ  one-hot, registered; marks the owner of the current transaction.
- done  out  NUM_REQ  one-cycle completion pulse to the owner.
- timeout  out  1  one-cycle pulse, coincident with done, when the watchdog expired.
- validCmd  out  1  one-cycle command strobe to the calculator.
- InA, InB  out  WIDTH  latched operands.
- sel  out  4  latched opcode.
- addr  out  8  latched address.
- rwMem  out  1  latched read/write bit.

## Operation
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE.
- IDLE:
  - Stays in IDLE unless calcActive=1 and |req=1.
  - When both hold, selects winner w as the first requester with req set, searching upward from ptr+1 modulo NUM_REQ.
  - Latches w's reqA, reqB, reqSel, reqAddr and reqRw into the output registers, sets grant=1<<w, then moves to ISSUE.
- ISSUE: drives validCmd=1 for exactly this cycle, then moves to WAIT_BUSY.
- WAIT_BUSY: moves to WAIT_DONE when busy=1.
- WAIT_DONE: moves to DONE when busy=0.
- DONE:
  - Drives done[w]=1 for one cycle.
  - Clears grant, sets ptr=w, and returns to IDLE.
- Operand outputs hold their values from the latch until the next grant. They never change while grant is nonzero.
- Requester contract: hold req and operands stable until done. A req that drops mid-transaction is ignored and the transaction still completes.
- calcActive falling mid-transaction has no effect on the current transaction; it only blocks the next grant.
- Simultaneous requests are resolved strictly round-robin; at most one grant is active at any time.
- req[w] still high in the DONE cycle is a new request. It competes in IDLE on the next cycle with lowest priority, because ptr=w.

## Timing
- Reset values:
  - state=IDLE, ptr=NUM_REQ-1, so requester 0 has first priority.
  - grant=0, done=0, timeout=0, validCmd=0.
  - InA=InB=0, sel=0, addr=0, rwMem=0.
- Latency:
  - req sampled high in IDLE at edge k.
  - grant and operands are valid and validCmd=1 in cycle k+1.
  - Minimum turnaround: busy high for 1 cycle gives done 3 cycles after validCmd.
- Back-to-back: the next validCmd comes no earlier than 2 cycles after done (IDLE, then ISSUE).
- Reset asserted in any state returns to the reset values immediately. No done pulse is emitted for the aborted transaction.

## Configuration
- CALC_ARB_TIMEOUT_EN defined:
  - A 32-bit counter clears on entry to WAIT_BUSY and counts in WAIT_BUSY and WAIT_DONE.
  - When the count reaches TIMEOUT_CYCLES-1, the FSM goes to DONE and asserts timeout=1 with done[w].
- CALC_ARB_TIMEOUT_EN undefined: no counter is built, timeout is tied to 0, and the arbiter waits indefinitely on busy.

## Structure
- Package calc_arb_pkg holds:
  - FSM state encoding, 3 bits.
  - OPCODE_W=4 and ADDR_W=8.
  - TIMEOUT_CNT_W=32.
- Sub-module rr_pick (combinational):
  - Inputs: req vector and ptr.
  - Outputs: winner index and a valid bit.
  - Instantiated once inside calc_cmd_arbiter.

## Test plan
- Single request: req=0001, reqA=8'h05, reqB=8'h03, reqSel=4'h0; busy high for 4 cycles → validCmd for 1 cycle, InA=5, InB=3, grant=0001, done=0001 one cycle after busy falls.
- Contention: req=1111 held continuously → grants in order 0001, 0010, 0100, 1000, 0001, with exactly one validCmd per grant.
- Gating: calcActive=0 with req=0010 → no grant over 20 cycles; calcActive→1 → grant=0010 on the next cycle.
- Watchdog (macro defined, TIMEOUT_CYCLES=16): busy held 0 after validCmd → done and timeout pulse together 16 cycles after entering WAIT_BUSY.
- Reset mid-op: reset driven 0 while in WAIT_DONE → grant, done, validCmd and operands all 0 immediately; after release, req=1000 → grant=1000 with no stale done.
- Request drop: req[2] deasserted during WAIT_BUSY → transaction completes and done[2] still pulses.
